// File: rtl/twoscomp_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : twoscomp_seq_if
// Brief    : Operand/result handshake bundle for the serial two's-complement
//            conversion unit (valid/ready on both input and output side).
// Revision : 1.0 - initial release
// ============================================================================
interface twoscomp_seq_if #(
  parameter int WIDTH = 24
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       mode;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             ovf;
  logic             zero;

  // Producer/consumer side (alignment shifter feeding, normaliser draining)
  modport master (
    output in_valid, mode, b, out_ready,
    input  in_ready, out_valid, out, ovf, zero
  );

  // Conversion unit side
  modport slave (
    input  in_valid, mode, b, out_ready,
    output in_ready, out_valid, out, ovf, zero
  );
endinterface
`default_nettype wire

// File: rtl/twoscomp_seq.sv
`default_nettype none
// ============================================================================
// Module   : twoscomp_seq
// Brief    : Multicycle two's-complement / sign-magnitude converter. Resolves
//            the carry one CHUNK-bit slice per clock (LSB slice first) so the
//            critical path is a single slice adder. Modes: pass, negate, abs,
//            ones' complement; flags overflow and zero result.
//            WIDTH must be an integer multiple of CHUNK.
// Revision : 1.0 - initial release
// ============================================================================
module twoscomp_seq #(
  parameter int WIDTH = 24,
  parameter int CHUNK = 4
) (
  input  wire logic       clk,
  input  wire logic       rst_n,
  twoscomp_seq_if.slave   bus
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  localparam logic [1:0] MODE_PASS = 2'b00;
  localparam logic [1:0] MODE_NEG  = 2'b01;
  localparam logic [1:0] MODE_ABS  = 2'b10;
  localparam logic [1:0] MODE_ONES = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [1:0]       mode_q, mode_d;
  logic             inv_q, inv_d;
  logic             carry_q, carry_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             out_valid_q, out_valid_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  logic [CHUNK-1:0] slice_in;
  logic [CHUNK:0]   slice_sum;
  logic [WIDTH-1:0] out_next;

  // Current slice: conditionally invert, add incoming carry, splice into result
  always_comb begin
    slice_in  = b_q[int'(idx_q)*CHUNK +: CHUNK] ^ {CHUNK{inv_q}};
    slice_sum = {1'b0, slice_in} + {{CHUNK{1'b0}}, carry_q};
    out_next  = out_q;
    out_next[int'(idx_q)*CHUNK +: CHUNK] = slice_sum[CHUNK-1:0];
  end

  // Next-state and next-output logic for the IDLE/RUN/DONE sequencer
  always_comb begin
    state_d     = state_q;
    b_d         = b_q;
    mode_d      = mode_q;
    inv_d       = inv_q;
    carry_d     = carry_q;
    idx_d       = idx_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    ovf_d       = ovf_q;
    zero_d      = zero_q;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          state_d = RUN;
          b_d     = bus.b;
          mode_d  = bus.mode;
          idx_d   = '0;
          ovf_d   = 1'b0;
          zero_d  = 1'b0;
          // Negation is invert-plus-one: the "+1" enters as the initial carry
          case (bus.mode)
            MODE_PASS: begin inv_d = 1'b0;            carry_d = 1'b0;            end
            MODE_NEG:  begin inv_d = 1'b1;            carry_d = 1'b1;            end
            MODE_ABS:  begin inv_d = bus.b[WIDTH-1];  carry_d = bus.b[WIDTH-1];  end
            default:   begin inv_d = 1'b1;            carry_d = 1'b0;            end
          endcase
        end
      end

      RUN: begin
        out_d   = out_next;
        carry_d = slice_sum[CHUNK];
        if (idx_q == LAST_IDX) begin
          // Final carry-out is dropped: the result wraps modulo 2^WIDTH
          state_d     = DONE;
          idx_d       = '0;
          out_valid_d = 1'b1;
          zero_d      = (out_next == '0);
          ovf_d       = ((mode_q == MODE_NEG) || (mode_q == MODE_ABS)) &&
                        (b_q == MOST_NEG);
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end

      DONE: begin
        if (bus.out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset aborts any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      b_q         <= '0;
      mode_q      <= MODE_PASS;
      inv_q       <= 1'b0;
      carry_q     <= 1'b0;
      idx_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      b_q         <= b_d;
      mode_q      <= mode_d;
      inv_q       <= inv_d;
      carry_q     <= carry_d;
      idx_q       <= idx_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      ovf_q       <= ovf_d;
      zero_q      <= zero_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.out       = out_q;
  assign bus.ovf       = ovf_q;
  assign bus.zero      = zero_q;

endmodule
`default_nettype wire

// File: doc/twoscomp_seq.md
Name: twoscomp_seq

Overview:
Parametrised, multicycle two's-complement / sign-magnitude conversion unit for the FPU mantissa datapath. It resolves the carry serially, one CHUNK-bit slice per clock, so the critical path is one slice adder instead of a full-width carry chain. It adds mode selection (pass, negate, absolute value, ones' complement), overflow and zero flags, and valid/ready handshakes on both sides so it can sit between the alignment shifter and the normaliser.

Parameters:
WIDTH, 24, operand/result width in bits; must be an integer multiple of CHUNK.
CHUNK, 4, slice width processed per cycle.
NCHUNK, WIDTH/CHUNK, derived local parameter; number of slices; not overridable.

Ports:
CLK  input  1  clock; all state changes on rising edge.
RST_N  input  1  asynchronous, active-low reset.
IN_VALID  input  1  operand and mode present.
IN_READY  output  1  unit can accept an operand; equals (state == IDLE).
MODE  input  2  00 pass, 01 negate, 10 abs, 11 ones' complement.
B  input  WIDTH  operand, two's-complement.
OUT_VALID  output  1  result available.
OUT_READY  input  1  downstream accepts the result.
OUT  output  WIDTH  result.
OVF  output  1  result not representable (negate/abs of the most-negative value).
ZERO  output  1  OUT is all zeros.

Behaviour:
- Clock and reset: one clock, CLK. RST_N is asynchronous and active-low.
- Reset (asynchronous, while RST_N=0): state=IDLE; OUT=0; OUT_VALID=0; OVF=0; ZERO=0; slice index=0; carry=0. IN_READY=1 during and after reset.
- FSM states: IDLE, RUN, DONE.
- IDLE -> RUN on IN_VALID & IN_READY.
  - Latch B and MODE.
  - Compute the invert flag INV:
    - pass: INV=0.
    - negate: INV=1.
    - abs: INV=B[WIDTH-1].
    - ones' complement: INV=1.
  - Initial carry = 1 only for negate, or abs with B[WIDTH-1]=1; otherwise 0.
  - Slice index = 0.
- RUN: one slice per edge, LSB slice first.
  - OUT[idx*CHUNK +: CHUNK] <= (B_slice ^ {CHUNK{INV}}) + carry.
  - carry <= carry-out of that slice.
  - idx increments.
  - The edge that processes slice NCHUNK-1 moves to DONE.
- Latency: OUT_VALID goes high exactly NCHUNK cycles after the acceptance edge (6 for the defaults).
- DONE: OUT_VALID=1 and OUT, OVF, ZERO are held stable.
  - Moves to IDLE on OUT_READY=1.
  - OUT_VALID drops the following cycle.
  - OUT keeps its last value until the next slice write.
- No acceptance while in RUN or DONE. IN_VALID is ignored; the latched B and MODE are unaffected by input changes.
- Throughput: one operation per NCHUNK+2 cycles when OUT_READY is held high.
- OVF is set in DONE iff MODE is negate or abs and the latched B = 1 followed by WIDTH-1 zeros. In that case OUT = the same pattern (wrapped). OVF is 0 for pass and ones' complement.
- ZERO is set in DONE iff OUT is all zeros. Negate of 0 gives ZERO=1, with the carry propagating through every slice and the final carry discarded.
- Final carry-out of slice NCHUNK-1 is discarded (modulo 2^WIDTH).
- Flags are valid only while OUT_VALID=1. They are cleared on the IDLE->RUN transition.
- Reset asserted in RUN or DONE aborts the operation immediately: no OUT_VALID pulse, and outputs take their reset values.

Test Plan:
1. Negate, WIDTH=24: B=0x000001, MODE=01.
   -> OUT=0xFFFFFF, OVF=0, ZERO=0.
   -> OUT_VALID rises exactly 6 cycles after the acceptance edge; IN_READY=0 throughout.
2. Full carry ripple: B=0x000000, MODE=01.
   -> OUT=0x000000, ZERO=1, OVF=0.
   -> B=0x000010, MODE=01 -> OUT=0xFFFFF0.
3. Abs: B=0xFFFFF0, MODE=10 -> OUT=0x000010, OVF=0.
   -> B=0x123456, MODE=10 -> OUT=0x123456.
   -> B=0x800000, MODE=10 -> OUT=0x800000, OVF=1.
4. Pass and ones' complement:
   -> B=0x0F0F0F, MODE=11 -> OUT=0xF0F0F0, OVF=0.
   -> B=0x0F0F0F, MODE=00 -> OUT=0x0F0F0F.
5. Backpressure: hold OUT_READY=0 for 5 cycles after OUT_VALID; drive IN_VALID=1 with a different B throughout.
   -> OUT, OVF and ZERO are stable.
   -> IN_READY=0 and the second operand is not accepted.
   -> On OUT_READY=1: state IDLE next cycle, then the second operand is accepted and processed correctly.
6. Reset and parameters: assert RST_N=0 after the slice-3 edge of a negate.
   -> OUT=0, OUT_VALID=0, IN_READY=1 with no clock edge required.
   -> After release, B=0x000005, MODE=01 -> OUT=0xFFFFFB.
   -> Repeat scenarios 1–3 with WIDTH=8, CHUNK=2: latency 4 cycles; MODE=01 on B=0x80 -> OUT=0x80, OVF=1.
